mem_lsu: RTL and testbench
==========================

# mem_lsu

Load/store unit that initiates byte-enabled accesses to the single-port data RAM: single-cycle writes, combinational reads. Accepts one RV32I load/store per handshake and decodes `funct3` into word address, byte lanes and shifted write data. Misaligned halfword/word accesses are split into two consecutive RAM cycles. Load data is returned aligned and sign- or zero-extended. Sits between the core's memory stage and the data RAM.

## Interface
- `ADDR_WIDTH`, 12: RAM word-address width; RAM holds 2**ADDR_WIDTH 32-bit words.
- `clk_i` in 1: clock; all state updates on rising edge.
- `rst_i` in 1: reset; one clock, reset synchronous and active-high.
- `req_valid_i` in 1: request present.
- `req_ready_o` out 1: unit idle, request accepted when both high at a rising edge.
- `req_we_i` in 1: 1 = store, 0 = load.
- `req_funct3_i` in 3: RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `req_addr_i` in 32: byte address; bits [ADDR_WIDTH+1:2] select word, [1:0] byte offset, upper bits ignored.
- `req_wdata_i` in 32: store data, right-aligned.
- `rsp_valid_o` out 1: one-cycle completion pulse.
- `rsp_rdata_o` out 32: extended load data, valid with `rsp_valid_o`; 0 for stores/errors.
- `rsp_err_o` out 1: illegal `funct3`, valid with `rsp_valid_o`.
- `ram_addr_o` out ADDR_WIDTH: RAM word address.
- `ram_din_o` out 32: RAM write data.
- `ram_we_o` out 1: RAM write strobe.
- `ram_be0_o`..`ram_be3_o` out 1 each: byte-lane enables, be0 = bits [7:0].
- `ram_dout_i` in 32: RAM read data, combinational from `ram_addr_o`.

## Operation
- States: IDLE, ACC0, ACC1, RESP.
- IDLE: `req_ready_o`=1. On accept, latch we/funct3/addr/wdata. Illegal `funct3` goes to RESP with err=1, no RAM cycle. Legal goes to ACC0. Illegal means 011/110/111 for loads; anything but 000/001/010 for stores.
- Size n = 1/2/4 bytes, offset o = addr[1:0], byte k (0..n-1) at position p = o+k. p<4 lands in word W, lane p; p>=4 lands in word W+1, lane p-4.
- ACC0: `ram_addr_o`=W, lanes for p<4. Stores: `ram_din_o` = wdata << 8*o, `ram_we_o`=1. Loads: capture `ram_dout_i` as low word. Next state ACC1 if o+n>4, else RESP.
- ACC1: `ram_addr_o` = W+1 modulo 2**ADDR_WIDTH (last word wraps to 0), lanes for p>=4. Stores: `ram_din_o` = wdata >> 8*(4-o). Loads: capture as high word. Next state RESP.
- RESP: `rsp_valid_o`=1. Load data = ({high,low} >> 8*o) truncated to n bytes; B/H sign-extend, BU/HU/W zero-extend. Next state IDLE.
- Outside ACC0/ACC1: `ram_we_o`=0, all be=0, `ram_addr_o`=0, `ram_din_o`=0.
- `ram_we_o` gated by `!rst_i`: no write in a cycle where reset is high.
- Reset (any state): next state IDLE, latched request and captured data cleared. Partially-done split store stays partial; no response issued.

## Timing
- Reset values: `req_ready_o`=1, `rsp_valid_o`=0, `rsp_rdata_o`=0, `rsp_err_o`=0, all `ram_*` outputs 0.
- Accepted at edge T. Aligned access in cycle T..T+1, response in cycle T+1..T+2. Split access adds one cycle. Illegal request responds in cycle T..T+1.
- `req_ready_o`=0 from acceptance through RESP, so no back-to-back acceptance; next accept at earliest at the edge ending RESP+IDLE cycle. Issue rate: 3 cycles aligned, 4 split.
- RAM writes commit at the edge ending ACC0/ACC1. Loads sample `ram_dout_i` at the same edge.

## Test plan
- Store SW 0xDEADBEEF at 0x10, then LW 0x10 -> word 4 written with be=1111 in one ACC0 cycle; rdata 0xDEADBEEF, 2 cycles after accept.
- RAM word 4 = 0x80FF7F01; LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; LH 0x12 -> 0xFFFF80FF; LHU 0x11 -> 0x0000FF7F.
- SH 0xA1B2 at 0x13 -> ACC0 word 4 be=1000 din[31:24]=0xB2; ACC1 word 5 be=0001 din[7:0]=0xA1. Then LH 0x13 -> 0xFFFFA1B2 via split, 3 cycles.
- ADDR_WIDTH=12, SW 0x11223344 at byte 0x3FFE -> word 0xFFF be=1100 lanes 0x44,0x33... exactly bytes 0x44,0x33 in lanes 2,3. Word 0 be=0011 lanes 0x22,0x11. LW 0x3FFE -> 0x11223344.
- Load funct3=011 and store funct3=100 -> `rsp_err_o`=1, rdata 0, no `ram_we_o`, response 1 cycle after accept.
- Assert `rst_i` during ACC1 of a split store -> no write that cycle, no `rsp_valid_o`. Next cycle IDLE with `req_ready_o`=1.

Source files
------------

// File: rtl/mem_lsu.sv
// mem_lsu: RV32I load/store unit in front of a single-port, byte-enabled data RAM.
//
// Accepts one load/store per handshake and decodes funct3 into a word address, byte lanes
// and lane-aligned write data. A halfword or word access that crosses a word boundary
// becomes two consecutive RAM cycles: ACC0 for the lower word, ACC1 for the next word.
// The next word wraps from the last RAM word to word 0. Load data comes back right-aligned
// and sign- or zero-extended, with a one-cycle response pulse.
//
// Ports:
//   clk_i, rst_i        clock; synchronous active-high reset
//   req_valid_i/ready_o request handshake; ready only while idle
//   req_we_i            1 = store, 0 = load
//   req_funct3_i        RV32I width code (B/H/W/BU/HU)
//   req_addr_i          byte address; bits above ADDR_WIDTH+1 ignored
//   req_wdata_i         right-aligned store data
//   rsp_valid_o         one-cycle completion pulse
//   rsp_rdata_o         extended load data (0 for stores and errors)
//   rsp_err_o           illegal funct3 for the requested direction
//   ram_addr_o          RAM word address
//   ram_din_o           RAM write data
//   ram_we_o            RAM write strobe
//   ram_be0_o..be3_o    RAM byte-lane enables, be0 = bits [7:0]
//   ram_dout_i          RAM read data, combinational from ram_addr_o
module mem_lsu #(
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [31:0]           req_addr_i,
  input  logic [31:0]           req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [31:0]           rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [31:0]           ram_din_o,
  output logic                  ram_we_o,
  output logic                  ram_be0_o,
  output logic                  ram_be1_o,
  output logic                  ram_be2_o,
  output logic                  ram_be3_o,
  input  logic [31:0]           ram_dout_i
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StAcc0 = 2'd1;
  localparam logic [1:0] StAcc1 = 2'd2;
  localparam logic [1:0] StResp = 2'd3;

  logic [1:0]              state_q, state_d;
  logic                    we_q, we_d;
  logic [2:0]              funct3_q, funct3_d;
  logic [ADDR_WIDTH+1:0]   addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    err_q, err_d;
  logic [31:0]             lo_q, lo_d;
  logic [31:0]             hi_q, hi_d;

  logic                    req_legal;
  logic [ADDR_WIDTH-1:0]   word_addr;
  logic [1:0]              offset;
  logic [3:0]              size_mask;
  logic [7:0]              lane_mask;
  logic                    split;
  logic [63:0]             wdata_shifted;
  logic [63:0]             rdata_shifted;
  logic [31:0]             load_data;
  logic [3:0]              ram_be;

  // Legal width codes differ by direction: stores have no unsigned variants.
  always_comb begin
    req_legal = 1'b0;
    if (req_we_i) begin
      req_legal = (req_funct3_i == 3'b000) || (req_funct3_i == 3'b001) ||
                  (req_funct3_i == 3'b010);
    end else begin
      req_legal = (req_funct3_i == 3'b000) || (req_funct3_i == 3'b001) ||
                  (req_funct3_i == 3'b010) || (req_funct3_i == 3'b100) ||
                  (req_funct3_i == 3'b101);
    end
  end

  assign word_addr = addr_q[ADDR_WIDTH+1:2];
  assign offset    = addr_q[1:0];

  always_comb begin
    size_mask = 4'b1111;
    unique case (funct3_q[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  end

  // Low nibble: lanes of the first word; high nibble: lanes spilling into the next word.
  assign lane_mask = {4'b0000, size_mask} << offset;
  assign split     = |lane_mask[7:4];

  // The upper half of the 64-bit shift is exactly wdata >> 8*(4-offset).
  assign wdata_shifted = {32'd0, wdata_q} << {offset, 3'b000};
  assign rdata_shifted = {hi_q, lo_q} >> {offset, 3'b000};

  always_comb begin
    load_data = rdata_shifted[31:0];
    unique case (funct3_q)
      3'b000:  load_data = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      3'b001:  load_data = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      3'b100:  load_data = {24'd0, rdata_shifted[7:0]};
      3'b101:  load_data = {16'd0, rdata_shifted[15:0]};
      default: load_data = rdata_shifted[31:0];
    endcase
  end

  // Next-state and request latching.
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          we_d     = req_we_i;
          funct3_d = req_funct3_i;
          addr_d   = req_addr_i[ADDR_WIDTH+1:0];
          wdata_d  = req_wdata_i;
          err_d    = !req_legal;
          lo_d     = 32'd0;
          hi_d     = 32'd0;
          state_d  = req_legal ? StAcc0 : StResp;
        end
      end
      StAcc0: begin
        if (!we_q) lo_d = ram_dout_i;
        state_d = split ? StAcc1 : StResp;
      end
      StAcc1: begin
        if (!we_q) hi_d = ram_dout_i;
        state_d = StResp;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      err_q    <= 1'b0;
      lo_q     <= 32'd0;
      hi_q     <= 32'd0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
    end
  end

  // Outputs are decoded from state; RAM signals are quiet outside the access states.
  always_comb begin
    req_ready_o = (state_q == StIdle);
    rsp_valid_o = 1'b0;
    rsp_rdata_o = 32'd0;
    rsp_err_o   = 1'b0;
    ram_addr_o  = '0;
    ram_din_o   = 32'd0;
    ram_we_o    = 1'b0;
    ram_be      = 4'b0000;
    unique case (state_q)
      StAcc0: begin
        ram_addr_o = word_addr;
        ram_din_o  = wdata_shifted[31:0];
        ram_we_o   = we_q && !rst_i;
        ram_be     = lane_mask[3:0];
      end
      StAcc1: begin
        ram_addr_o = word_addr + ADDR_WIDTH'(1);
        ram_din_o  = wdata_shifted[63:32];
        ram_we_o   = we_q && !rst_i;
        ram_be     = lane_mask[7:4];
      end
      StResp: begin
        rsp_valid_o = 1'b1;
        rsp_err_o   = err_q;
        rsp_rdata_o = (err_q || we_q) ? 32'd0 : load_data;
      end
      default: ;
    endcase
  end

  assign ram_be0_o = ram_be[0];
  assign ram_be1_o = ram_be[1];
  assign ram_be2_o = ram_be[2];
  assign ram_be3_o = ram_be[3];

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu with a behavioural byte-enabled RAM.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [11:0] ram_addr;
  logic [31:0] ram_din;
  logic        ram_we;
  logic        ram_be0, ram_be1, ram_be2, ram_be3;
  logic [31:0] ram_dout;

  logic [31:0] mem [0:4095];

  int          n_checks = 0;
  int          n_fail = 0;
  int          lat;
  int          n_tr;
  logic        any_we;
  logic [31:0] tr_addr [0:3];
  logic [31:0] tr_be   [0:3];
  logic [31:0] tr_din  [0:3];
  logic [31:0] r_data;
  logic        r_err;

  always #5 clk = ~clk;

  mem_lsu #(.ADDR_WIDTH(12)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_funct3_i (req_funct3),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .rsp_valid_o  (rsp_valid),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_err_o    (rsp_err),
    .ram_addr_o   (ram_addr),
    .ram_din_o    (ram_din),
    .ram_we_o     (ram_we),
    .ram_be0_o    (ram_be0),
    .ram_be1_o    (ram_be1),
    .ram_be2_o    (ram_be2),
    .ram_be3_o    (ram_be3),
    .ram_dout_i   (ram_dout)
  );

  assign ram_dout = mem[ram_addr];

  always @(posedge clk) begin
    if (ram_we) begin
      if (ram_be0) mem[ram_addr][7:0]   <= ram_din[7:0];
      if (ram_be1) mem[ram_addr][15:8]  <= ram_din[15:8];
      if (ram_be2) mem[ram_addr][23:16] <= ram_din[23:16];
      if (ram_be3) mem[ram_addr][31:24] <= ram_din[31:24];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request and trace RAM activity until the response (bounded to 10 cycles).
  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n_tr   = 0;
    any_we = 1'b0;
    lat    = 1;
    while (!rsp_valid && lat < 10) begin
      if (ram_we) any_we = 1'b1;
      if (n_tr < 4) begin
        tr_addr[n_tr] = 32'(ram_addr);
        tr_be[n_tr]   = {28'd0, ram_be3, ram_be2, ram_be1, ram_be0};
        tr_din[n_tr]  = ram_din;
        n_tr++;
      end
      @(negedge clk);
      lat++;
    end
    r_data = rsp_rdata;
    r_err  = rsp_err;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_din", ram_din, 32'd0);
    check("rst_ram_be", {28'd0, ram_be3, ram_be2, ram_be1, ram_be0}, 32'd0);

    // SW / LW aligned
    xact(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    check("sw_lat", 32'(lat), 32'd2);
    check("sw_ncyc", 32'(n_tr), 32'd1);
    check("sw_addr", tr_addr[0], 32'd4);
    check("sw_be", tr_be[0], 32'hF);
    check("sw_din", tr_din[0], 32'hDEADBEEF);
    check("sw_mem", mem[4], 32'hDEADBEEF);
    check("sw_rdata", r_data, 32'd0);
    check("ready_in_resp", 32'(req_ready), 32'd0);
    xact(1'b0, 3'b010, 32'h10, 32'd0);
    check("lw_lat", 32'(lat), 32'd2);
    check("lw_rdata", r_data, 32'hDEADBEEF);
    check("lw_err", 32'(r_err), 32'd0);

    // Sub-word loads from 0x80FF7F01
    xact(1'b1, 3'b010, 32'h10, 32'h80FF7F01);
    xact(1'b0, 3'b000, 32'h13, 32'd0);
    check("lb", r_data, 32'hFFFFFF80);
    xact(1'b0, 3'b100, 32'h13, 32'd0);
    check("lbu", r_data, 32'h00000080);
    xact(1'b0, 3'b001, 32'h12, 32'd0);
    check("lh", r_data, 32'hFFFF80FF);
    xact(1'b0, 3'b101, 32'h11, 32'd0);
    check("lhu", r_data, 32'h0000FF7F);
    check("lhu_lat", 32'(lat), 32'd2);

    // Split SH across words 4/5
    xact(1'b1, 3'b001, 32'h13, 32'h0000A1B2);
    check("sh_split_lat", 32'(lat), 32'd3);
    check("sh_acc0_addr", tr_addr[0], 32'd4);
    check("sh_acc0_be", tr_be[0], 32'h8);
    check("sh_acc0_din", tr_din[0], 32'hB2000000);
    check("sh_acc1_addr", tr_addr[1], 32'd5);
    check("sh_acc1_be", tr_be[1], 32'h1);
    check("sh_acc1_din", tr_din[1], 32'h000000A1);
    check("sh_mem4", mem[4], 32'hB2FF7F01);
    check("sh_mem5", mem[5], 32'h000000A1);
    xact(1'b0, 3'b001, 32'h13, 32'd0);
    check("lh_split_lat", 32'(lat), 32'd3);
    check("lh_split", r_data, 32'hFFFFA1B2);

    // Split SW wrapping from the last word to word 0
    xact(1'b1, 3'b010, 32'h3FFE, 32'h11223344);
    check("wrap_lat", 32'(lat), 32'd3);
    check("wrap_acc0_addr", tr_addr[0], 32'hFFF);
    check("wrap_acc0_be", tr_be[0], 32'hC);
    check("wrap_acc0_din", tr_din[0], 32'h33440000);
    check("wrap_acc1_addr", tr_addr[1], 32'd0);
    check("wrap_acc1_be", tr_be[1], 32'h3);
    check("wrap_acc1_din", tr_din[1], 32'h00001122);
    check("wrap_mem_fff", mem[12'hFFF], 32'h33440000);
    check("wrap_mem_0", mem[0], 32'h00001122);
    xact(1'b0, 3'b010, 32'h3FFE, 32'd0);
    check("wrap_lw", r_data, 32'h11223344);

    // Illegal funct3
    xact(1'b0, 3'b011, 32'h10, 32'd0);
    check("ill_ld_lat", 32'(lat), 32'd1);
    check("ill_ld_err", 32'(r_err), 32'd1);
    check("ill_ld_rdata", r_data, 32'd0);
    check("ill_ld_we", 32'(any_we), 32'd0);
    xact(1'b1, 3'b100, 32'h10, 32'h55555555);
    check("ill_st_lat", 32'(lat), 32'd1);
    check("ill_st_err", 32'(r_err), 32'd1);
    check("ill_st_rdata", r_data, 32'd0);
    check("ill_st_we", 32'(any_we), 32'd0);
    check("ill_st_mem", mem[4], 32'hB2FF7F01);

    // Reset during ACC1 of a split store at 0x81 (words 0x20/0x21)
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h81;
    req_wdata  = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rstsplit_acc0_we", 32'(ram_we), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstsplit_acc1_we", 32'(ram_we), 32'd0);
    check("rstsplit_no_rsp", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("rstsplit_ready", 32'(req_ready), 32'd1);
    check("rstsplit_no_rsp2", 32'(rsp_valid), 32'd0);
    check("rstsplit_mem20", mem[12'h020], 32'hFEF00D00);
    check("rstsplit_mem21", mem[12'h021], 32'd0);
    @(negedge clk);
    check("rstsplit_no_rsp3", 32'(rsp_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
